// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: pad drive/enable, synchronised pad sampling,
// per-pin edge capture into a W1C status register and a level interrupt.
module gpio_bank #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_W      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   input  logic [WIDTH-1:0]  pad_in,
   output logic [WIDTH-1:0]  pad_out,
   output logic [WIDTH-1:0]  pad_oe,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] ADDR_DATA     = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_TRIS     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_PINSTATE = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_EDGE     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = ADDR_W'(5);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] oe_q;      // stored inverted so pad_oe comes straight from a flop
   logic [WIDTH-1:0] irq_en_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] status_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   logic [WIDTH-1:0] pinstate;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] status_clr;
   logic [WIDTH-1:0] status_nxt;
   logic [WIDTH-1:0] rd_mux;

   assign pinstate = sync_q[SYNC_STAGES-1];
   assign rise     = pinstate & ~prev_q;
   assign fall     = ~pinstate & prev_q;
   assign hit      = (edge_q & fall) | (~edge_q & rise);

   // A hit in the same cycle as a clear of that bit keeps it set.
   always_comb begin
      status_clr = '0;
      if (wr_en && (addr == ADDR_STATUS)) begin
         status_clr = wdata;
      end
      status_nxt = (status_q & ~status_clr) | hit;
   end

   // Read mux sees pre-write register values; reserved addresses read 0.
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_DATA:     rd_mux = data_q;
         ADDR_TRIS:     rd_mux = ~oe_q;
         ADDR_PINSTATE: rd_mux = pinstate;
         ADDR_IRQ_EN:   rd_mux = irq_en_q;
         ADDR_EDGE:     rd_mux = edge_q;
         ADDR_STATUS:   rd_mux = status_q;
         default:       rd_mux = '0;
      endcase
   end

   // Control/status registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q   <= '0;
         oe_q     <= '0;
         irq_en_q <= '0;
         edge_q   <= '0;
         status_q <= '0;
      end else begin
         if (wr_en) begin
            case (addr)
               ADDR_DATA:   data_q   <= wdata;
               ADDR_TRIS:   oe_q     <= ~wdata;
               ADDR_IRQ_EN: irq_en_q <= wdata;
               ADDR_EDGE:   edge_q   <= wdata;
               default:     ;
            endcase
         end
         status_q <= status_nxt;
      end
   end

   // Input synchroniser chain and previous-sample register for edge detect.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= pad_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= pinstate;
      end
   end

   // Registered read port; rdata holds between reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= rd_mux;
         end
      end
   end

   assign pad_out = data_q;
   assign pad_oe  = oe_q;
   assign irq     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: reads go through an expected-data queue
// checked by an independent monitor; pad/irq levels are checked inline.
module tb_gpio_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        rvalid;
   logic [15:0] pad_in;
   logic [15:0] pad_out;
   logic [15:0] pad_oe;
   logic        irq;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   string       name_q[$];

   gpio_bank #(.WIDTH(16), .SYNC_STAGES(2), .ADDR_W(3)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .pad_in(pad_in),
      .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every rvalid pulse must match the oldest queued read.
   always @(negedge clk) begin
      if (rvalid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rvalid: rdata=%h with no read outstanding", rdata);
         end else begin
            automatic logic [15:0] e = exp_q.pop_front();
            automatic string       n = name_q.pop_front();
            if (rdata !== e) begin
               n_bad++;
               $display("FAIL %s: got %h expected %h", n, rdata, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
      rd_en = 1'b1;
      addr  = a;
      exp_q.push_back(exp);
      name_q.push_back(name);
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      pad_in = 16'hFFFF;
      #1;
      ticks(2);
      check("reset_pad_oe", pad_oe, 16'h0000);
      check("reset_pad_out", pad_out, 16'h0000);
      check("reset_irq", {15'd0, irq}, 16'h0000);
      check("reset_rvalid", {15'd0, rvalid}, 16'h0000);
      check("reset_rdata", rdata, 16'h0000);

      // Pads high out of reset look like rising edges on every pin.
      reset = 1'b1;
      rd(3'd1, 16'hFFFF, "reset_tris");
      pad_in = 16'h0000;
      ticks(4);
      rd(3'd5, 16'hFFFF, "startup_status");
      rd(3'd2, 16'h0000, "pinstate_low");
      wr(3'd5, 16'hFFFF);
      rd(3'd5, 16'h0000, "status_cleared");

      // Output drive
      wr(3'd1, 16'h00F0);
      check("pad_oe_on_write", pad_oe, 16'hFF0F);
      wr(3'd0, 16'hA5A5);
      check("pad_out_on_write", pad_out, 16'hA5A5);
      rd(3'd0, 16'hA5A5, "data_readback");
      rd(3'd1, 16'h00F0, "tris_readback");

      // Sync latency on pin 3
      wr(3'd3, 16'h0008);
      pad_in[3] = 1'b1;
      tick();
      check("irq_edge_k", {15'd0, irq}, 16'h0000);
      rd(3'd2, 16'h0000, "pinstate_at_k1");
      check("irq_edge_k1", {15'd0, irq}, 16'h0000);
      rd(3'd2, 16'h0008, "pinstate_after_k1");
      check("irq_edge_k2", {15'd0, irq}, 16'h0001);
      rd(3'd5, 16'h0008, "status_pin3");

      // Falling-edge polarity on pin 5
      wr(3'd5, 16'h0008);
      check("irq_after_clear", {15'd0, irq}, 16'h0000);
      wr(3'd4, 16'h0020);
      pad_in[5] = 1'b1;
      ticks(4);
      rd(3'd5, 16'h0000, "no_set_on_rise");
      pad_in[5] = 1'b0;
      ticks(4);
      rd(3'd5, 16'h0020, "set_on_fall");
      check("irq_masked", {15'd0, irq}, 16'h0000);
      wr(3'd5, 16'h0020);

      // W1C race on pin 3
      pad_in[3] = 1'b0;
      ticks(4);
      pad_in[3] = 1'b1;
      ticks(4);
      check("irq_pin3_set", {15'd0, irq}, 16'h0001);
      pad_in[3] = 1'b0;
      ticks(4);
      pad_in[3] = 1'b1;
      ticks(2);
      wr(3'd5, 16'h0008);
      check("irq_race_holds", {15'd0, irq}, 16'h0001);
      rd(3'd5, 16'h0008, "status_race_holds");
      wr(3'd5, 16'h0008);
      check("irq_cleared", {15'd0, irq}, 16'h0000);
      rd(3'd5, 16'h0000, "status_cleared_again");

      // Read-only and reserved addresses
      wr(3'd2, 16'h1234);
      wr(3'd7, 16'h1234);
      rd(3'd2, 16'h0008, "pinstate_ro");
      rd(3'd7, 16'h0000, "reserved_7");
      rd(3'd6, 16'h0000, "reserved_6");

      // Simultaneous read and write returns the old value
      wr_en = 1'b1; wdata = 16'h3C3C;
      rd(3'd0, 16'hA5A5, "rd_wr_same_addr");
      wr_en = 1'b0;
      rd(3'd0, 16'h3C3C, "data_after_rdwr");

      // Reset during a read aborts it
      reset = 1'b0;
      rd_en = 1'b1; addr = 3'd0;
      tick();
      rd_en = 1'b0;
      check("midreset_rvalid", {15'd0, rvalid}, 16'h0000);
      check("midreset_pad_out", pad_out, 16'h0000);
      check("midreset_pad_oe", pad_oe, 16'h0000);
      check("midreset_irq", {15'd0, irq}, 16'h0000);
      reset = 1'b1;
      rd(3'd5, 16'h0000, "status_after_reset");
      ticks(3);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL reads_outstanding: got %0d expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised GPIO bank, the next generation of the fixed 16-bit datareg/tristate/pinstate GPIO path between the pad ring and the chip core. Adds input synchronisation, per-pin edge interrupts with selectable polarity, and a write-1-to-clear status register. All of it is behind a simple single-cycle register port used by the core. It sits between the core bus and the pad ring: `pad_out`/`pad_oe` drive the bidirectional pad cells and `pad_in` returns the pad value.

Parameters:
- WIDTH, 16, number of GPIO pins (1..32).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (>=2).
- ADDR_W, 3, register address width.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- `wr_en`  in  1  register write strobe, one cycle.
- `rd_en`  in  1  register read strobe, one cycle.
- `addr`  in  ADDR_W  register select.
- `wdata`  in  WIDTH  write data.
- `rdata`  out  WIDTH  registered read data.
- `rvalid`  out  1  high for the cycle `rdata` is valid.
- `pad_in`  in  WIDTH  raw asynchronous pad input.
- `pad_out`  out  WIDTH  pad output value (= DATA).
- `pad_oe`  out  WIDTH  pad output enable (= ~TRIS).
- `irq`  out  1  level interrupt = |(STATUS & IRQ_EN).

Behaviour:
- Register map:
  - 0 DATA, RW.
  - 1 TRIS, RW; 1 = pin is input/tristated.
  - 2 PINSTATE, RO; synchronised pad value.
  - 3 IRQ_EN, RW.
  - 4 EDGE, RW; 0 = rising, 1 = falling.
  - 5 STATUS, W1C.
  - 6..7 reserved: read 0, writes ignored.
  - Writes to PINSTATE are ignored.
- Reset (reset==0 at edge):
  - DATA=0, TRIS=all 1, IRQ_EN=0, EDGE=0, STATUS=0.
  - Synchroniser flops and prev-sample register = 0.
  - `rdata`=0, `rvalid`=0.
  - Outputs therefore come up `pad_oe`=0, `pad_out`=0, `irq`=0.
  - Reset mid-operation aborts any read (`rvalid` low next cycle) and discards a pending edge.
- Writes: take effect at the `clk` edge where `wr_en`=1. `pad_out`/`pad_oe` change that same edge.
- Reads:
  - `rd_en` at edge N → `rdata`/`rvalid` registered at edge N; valid during cycle N..N+1. Latency 1 cycle.
  - `rvalid` is a 1-cycle pulse. `rdata` holds its last value when `rvalid`=0.
  - Simultaneous `rd_en` and `wr_en` to the same address returns the pre-write value.
- Synchroniser: `pad_in` passes through SYNC_STAGES flops. A change sampled at edge k appears in PINSTATE after edge k+SYNC_STAGES-1.
- Edge detect, per pin:
  - prev <= PINSTATE every cycle.
  - rise = PINSTATE & ~prev; fall = ~PINSTATE & prev.
  - hit = EDGE ? fall : rise. A hit sets the STATUS bit at the next edge, i.e. after edge k+SYNC_STAGES.
  - Edges are detected regardless of TRIS and IRQ_EN. IRQ_EN gates `irq` only.
- STATUS update, per bit: STATUS <= (STATUS & ~(wr_en && addr==5 ? wdata : 0)) | hit.
  - A hit in the same cycle as a W1C clear of that bit wins: the bit stays set.
- `irq` is combinational from registered STATUS and IRQ_EN, so it has no extra latency. It deasserts the cycle after the last enabled bit is cleared or disabled.
- Changing EDGE does not itself generate a hit; only PINSTATE transitions do.
- Unused upper `wdata`/`rdata` bits do not exist (all regs are WIDTH wide).

Test Plan:
- Reset: hold reset=0 for 2 cycles with `pad_in`=16'hFFFF → `pad_oe`=0, `pad_out`=0, `irq`=0, `rvalid`=0. Read TRIS → 16'hFFFF with `rvalid` 1 cycle after `rd_en`.
- Output drive: write TRIS=16'h00F0, DATA=16'hA5A5 → `pad_oe`=16'hFF0F and `pad_out`=16'hA5A5 on the write edge. Read DATA back → 16'hA5A5.
- Sync latency: SYNC_STAGES=2, `pad_in`[3] 0→1 sampled at edge k → PINSTATE[3]=1 after edge k+1; STATUS[3]=1 after edge k+2. With IRQ_EN=16'h0008, `irq`=1 in the same cycle.
- Polarity: EDGE[5]=1, pulse `pad_in`[5] 0→1→0 (4 cycles each) → STATUS only 16'h0020 after the falling edge; no set on the rise.
- W1C race: STATUS[3]=1, write STATUS=16'h0008 in the same cycle a new rising hit on pin 3 → STATUS[3] stays 1 and `irq` stays 1. Clear again with no hit → STATUS=0, `irq`=0 next cycle.
- Reserved/RO: write 16'h1234 to addr 2 and addr 7, then read both → PINSTATE unchanged and addr 7 reads 0.
